// File: rtl/laner_pkg.sv
// rtl/laner_pkg.sv - shared playfield geometry, colours, win score and win-sequencer state encoding
package laner_pkg;

   localparam int XSCREEN      = 640;
   localparam int YSCREEN      = 480;
   localparam int NUM_LANES    = 5;
   localparam int LANE_WIDTH   = 80;
   localparam int LANE_START_X = 120;

   localparam int X_W = 10;
   localparam int Y_W = 9;
   localparam int C_W = 9;

   localparam logic [C_W-1:0] COLOR_BLACK = 9'b000_000_000;
   localparam logic [C_W-1:0] COLOR_GREEN = 9'b000_111_000;

   localparam int WIN_SCORE = 333;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      START,
      WAIT_WS,
      HOLD,
      DONE
   } win_state_t;

   // Counter width that stays legal (>= 1 bit) even for a terminal count of 1.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rect_fill_sweeper.sv
// rtl/rect_fill_sweeper.sv - raster sweep over a rectangle, one registered pixel write per cycle
module rect_fill_sweeper
   import laner_pkg::*;
#(
   parameter int              X0           = LANE_START_X,
   parameter int              X1           = LANE_START_X + NUM_LANES * LANE_WIDTH - 1,
   parameter int              Y0           = 0,
   parameter int              Y1           = YSCREEN - 1,
   parameter logic [C_W-1:0]  FILL_COLOR   = COLOR_BLACK,
   parameter bit              BORDER_EN    = 1'b0,
   parameter logic [C_W-1:0]  BORDER_COLOR = COLOR_GREEN
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             start,
   output logic [X_W-1:0]   px_x,
   output logic [Y_W-1:0]   px_y,
   output logic [C_W-1:0]   px_color,
   output logic             px_write,
   output logic             last
);

   localparam logic [X_W-1:0] XL0 = X_W'(X0);
   localparam logic [X_W-1:0] XL1 = X_W'(X1);
   localparam logic [Y_W-1:0] YL0 = Y_W'(Y0);
   localparam logic [Y_W-1:0] YL1 = Y_W'(Y1);

   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic           active;
   logic           on_border;
   logic [C_W-1:0] pix_color;

   // Border is two pixels thick on every edge of the rectangle.
   always_comb begin
      on_border = (cx == XL0) || (cx == XL0 + 1'b1) ||
                  (cx == XL1 - 1'b1) || (cx == XL1) ||
                  (cy == YL0) || (cy == YL0 + 1'b1) ||
                  (cy == YL1 - 1'b1) || (cy == YL1);
      pix_color = (BORDER_EN && on_border) ? BORDER_COLOR : FILL_COLOR;
   end

   assign last = active && (cx == XL1) && (cy == YL1);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         cx       <= '0;
         cy       <= '0;
         active   <= 1'b0;
         px_x     <= '0;
         px_y     <= '0;
         px_color <= '0;
         px_write <= 1'b0;
      end else begin
         px_write <= active;
         if (active) begin
            px_x     <= cx;
            px_y     <= cy;
            px_color <= pix_color;
         end
         if (start) begin
            cx     <= XL0;
            cy     <= YL0;
            active <= 1'b1;
         end else if (active) begin
            if (last) begin
               active <= 1'b0;
            end else if (cx == XL1) begin
               cx <= XL0;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/win_sequencer.sv
// rtl/win_sequencer.sv - win sequence: clear playfield, run win_screen renderer, hold, report done
// Define WIN_SEQ_BORDER_EN to draw a BORDER_COLOR frame around the cleared area.
module win_sequencer
   import laner_pkg::*;
#(
   parameter int              CLEAR_X0     = LANE_START_X,
   parameter int              CLEAR_X1     = LANE_START_X + NUM_LANES * LANE_WIDTH - 1,
   parameter int              CLEAR_Y0     = 0,
   parameter int              CLEAR_Y1     = YSCREEN - 1,
   parameter logic [C_W-1:0]  CLEAR_COLOR  = COLOR_BLACK,
   parameter int              HOLD_CYCLES  = 50_000_000,
   parameter logic [C_W-1:0]  BORDER_COLOR = COLOR_GREEN
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             win_trigger,
   input  logic             ws_complete,
   input  logic [X_W-1:0]   ws_VGA_x,
   input  logic [Y_W-1:0]   ws_VGA_y,
   input  logic [C_W-1:0]   ws_VGA_color,
   input  logic             ws_VGA_write,
   output logic             ws_enable,
   output logic             busy,
   output logic             done,
   output logic [X_W-1:0]   VGA_x,
   output logic [Y_W-1:0]   VGA_y,
   output logic [C_W-1:0]   VGA_color,
   output logic             VGA_write
);

`ifdef WIN_SEQ_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   localparam int             HW        = clog2_min1(HOLD_CYCLES);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

   win_state_t     state, state_n;
   logic           ws_enable_n, busy_n, done_n;
   logic [HW-1:0]  hold_cnt, hold_cnt_n;
   logic           trig_prev, armed, trigger_rise;
   logic           sweep_start, sweep_last;

   logic [X_W-1:0] clr_x;
   logic [Y_W-1:0] clr_y;
   logic [C_W-1:0] clr_color;
   logic           clr_write;

   rect_fill_sweeper #(
      .X0           (CLEAR_X0),
      .X1           (CLEAR_X1),
      .Y0           (CLEAR_Y0),
      .Y1           (CLEAR_Y1),
      .FILL_COLOR   (CLEAR_COLOR),
      .BORDER_EN    (BORDER_EN),
      .BORDER_COLOR (BORDER_COLOR)
   ) u_sweeper (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .start    (sweep_start),
      .px_x     (clr_x),
      .px_y     (clr_y),
      .px_color (clr_color),
      .px_write (clr_write),
      .last     (sweep_last)
   );

   // armed only goes high once the trigger has been seen low, so a level held
   // through reset cannot masquerade as a fresh rising edge.
   assign trigger_rise = win_trigger & ~trig_prev & armed;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         trig_prev <= 1'b0;
         armed     <= ~win_trigger;
      end else begin
         trig_prev <= win_trigger;
         if (!win_trigger) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state     <= IDLE;
         ws_enable <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_n;
         ws_enable <= ws_enable_n;
         busy      <= busy_n;
         done      <= done_n;
         hold_cnt  <= hold_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      ws_enable_n = ws_enable;
      busy_n      = busy;
      done_n      = done;
      hold_cnt_n  = hold_cnt;
      sweep_start = 1'b0;
      case (state)
         IDLE: begin
            busy_n = 1'b0;
            done_n = 1'b0;
            if (trigger_rise) begin
               sweep_start = 1'b1;
               busy_n      = 1'b1;
               state_n     = CLEAR;
            end
         end
         CLEAR: begin
            if (sweep_last) begin
               state_n = START;
            end
         end
         START: begin
            ws_enable_n = 1'b1;
            state_n     = WAIT_WS;
         end
         WAIT_WS: begin
            if (ws_complete) begin
               hold_cnt_n = '0;
               state_n    = HOLD;
            end
         end
         // enable stays high so the renderer parks in its DONE state
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               ws_enable_n = 1'b0;
               done_n      = 1'b1;
               busy_n      = 1'b0;
               state_n     = DONE;
            end else begin
               hold_cnt_n = hold_cnt + 1'b1;
            end
         end
         DONE: begin
            done_n = 1'b1;
            if (!win_trigger) begin
               done_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      if (ws_enable) begin
         VGA_x     = ws_VGA_x;
         VGA_y     = ws_VGA_y;
         VGA_color = ws_VGA_color;
         VGA_write = ws_VGA_write;
      end else begin
         VGA_x     = clr_x;
         VGA_y     = clr_y;
         VGA_color = clr_color;
         VGA_write = clr_write;
      end
   end

endmodule

// File: tb/tb_win_sequencer.sv
// tb/tb_win_sequencer.sv - randomized self-checking bench for win_sequencer with a renderer model
module tb_win_sequencer;

   localparam int         X0    = 2;
   localparam int         X1    = 5;
   localparam int         Y0    = 1;
   localparam int         Y1    = 2;
   localparam int         HOLD  = 5;
   localparam logic [8:0] CLR   = 9'b000_000_000;
   localparam logic [8:0] BRD   = 9'b000_111_000;
   localparam logic [8:0] GREEN = 9'b000_111_000;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       win_trigger = 1'b0;
   logic       ws_complete = 1'b0;
   logic [9:0] ws_VGA_x = '0;
   logic [8:0] ws_VGA_y = '0;
   logic [8:0] ws_VGA_color = '0;
   logic       ws_VGA_write = 1'b0;
   logic       ws_enable, busy, done, VGA_write;
   logic [9:0] VGA_x;
   logic [8:0] VGA_y, VGA_color;

   int total = 0;
   int bad = 0;

   typedef struct {
      int x;
      int y;
   } pix_t;
   pix_t exp_q[$];

   always #5 Clock = ~Clock;

   win_sequencer #(
      .CLEAR_X0     (X0),
      .CLEAR_X1     (X1),
      .CLEAR_Y0     (Y0),
      .CLEAR_Y1     (Y1),
      .CLEAR_COLOR  (CLR),
      .HOLD_CYCLES  (HOLD),
      .BORDER_COLOR (BRD)
   ) dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .win_trigger  (win_trigger),
      .ws_complete  (ws_complete),
      .ws_VGA_x     (ws_VGA_x),
      .ws_VGA_y     (ws_VGA_y),
      .ws_VGA_color (ws_VGA_color),
      .ws_VGA_write (ws_VGA_write),
      .ws_enable    (ws_enable),
      .busy         (busy),
      .done         (done),
      .VGA_x        (VGA_x),
      .VGA_y        (VGA_y),
      .VGA_color    (VGA_color),
      .VGA_write    (VGA_write)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge Clock);
   endtask

   function automatic logic [8:0] exp_color(input int x, input int y);
`ifdef WIN_SEQ_BORDER_EN
      if (x == X0 || x == X0 + 1 || x == X1 - 1 || x == X1 ||
          y == Y0 || y == Y0 + 1 || y == Y1 - 1 || y == Y1)
         return BRD;
`endif
      return CLR;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_wsen"}, ws_enable, 0);
      check({tag, "_wr"}, VGA_write, 0);
   endtask

   task automatic run_seq(input bit drop_mid, input bit abort_in_wait);
      int drop_at;
      int nw;
      drop_at = $urandom_range(0, exp_q.size() - 3);
      cyc();
      win_trigger = 1'b1;
      cyc();
      check("clear_entry_wr", VGA_write, 0);
      check("clear_entry_busy", busy, 1);
      for (int k = 0; k < exp_q.size(); k++) begin
         if (drop_mid && k == drop_at)     win_trigger = 1'b0;
         if (drop_mid && k == drop_at + 1) win_trigger = 1'b1;
         cyc();
         check("clr_wr", VGA_write, 1);
         check("clr_x", VGA_x, exp_q[k].x);
         check("clr_y", VGA_y, exp_q[k].y);
         check("clr_color", VGA_color, exp_color(exp_q[k].x, exp_q[k].y));
         check("clr_busy", busy, 1);
         check("clr_wsen", ws_enable, 0);
      end
      cyc();
      check("wsen_rise", ws_enable, 1);
      check("wait_busy", busy, 1);
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) begin
         if (i == 0) begin
            ws_VGA_x = 10'd10; ws_VGA_y = 9'd20; ws_VGA_color = GREEN; ws_VGA_write = 1'b1;
         end else begin
            ws_VGA_x     = 10'($urandom_range(0, 639));
            ws_VGA_y     = 9'($urandom_range(0, 479));
            ws_VGA_color = 9'($urandom_range(0, 511));
            ws_VGA_write = 1'($urandom_range(0, 1));
         end
         #1;
         check("pass_x", VGA_x, ws_VGA_x);
         check("pass_y", VGA_y, ws_VGA_y);
         check("pass_color", VGA_color, ws_VGA_color);
         check("pass_wr", VGA_write, ws_VGA_write);
         check("wait_done", done, 0);
         cyc();
      end
      if (abort_in_wait) begin
         ws_VGA_write = 1'b1;
         ws_VGA_x = 10'd77; ws_VGA_y = 9'd33; ws_VGA_color = 9'h1ff;
         Resetn = 1'b0;
         cyc();
         check_idle_outputs("rst");
         check("rst_x", VGA_x, 0);
         check("rst_y", VGA_y, 0);
         check("rst_color", VGA_color, 0);
         cyc();
         Resetn = 1'b1;
         for (int i = 0; i < 6; i++) begin
            cyc();
            check_idle_outputs("held_trig");
         end
         ws_VGA_write = 1'b0;
         win_trigger = 1'b0;
         cyc();
         return;
      end
      ws_VGA_write = 1'b0;
      ws_complete = 1'b1;
      cyc();
      check("hold0_done", done, 0);
      check("hold0_wsen", ws_enable, 1);
      for (int k = 1; k <= HOLD; k++) begin
         cyc();
         check("hold_done", done, (k == HOLD) ? 1 : 0);
         check("hold_wsen", ws_enable, (k == HOLD) ? 0 : 1);
         check("hold_busy", busy, (k == HOLD) ? 0 : 1);
      end
      ws_complete = 1'b0;
      win_trigger = 1'b1;
      for (int i = 0; i < $urandom_range(1, 4); i++) begin
         cyc();
         check("done_level", done, 1);
         check("done_busy", busy, 0);
         check("done_wr", VGA_write, 0);
      end
      win_trigger = 1'b0;
      cyc();
      check_idle_outputs("exit");
   endtask

   initial begin
      for (int y = Y0; y <= Y1; y++)
         for (int x = X0; x <= X1; x++)
            exp_q.push_back('{x: x, y: y});
      repeat (3) cyc();
      check_idle_outputs("reset");
      check("reset_x", VGA_x, 0);
      check("reset_y", VGA_y, 0);
      Resetn = 1'b1;
      cyc();
      check_idle_outputs("post_reset");
      run_seq(1'b0, 1'b0);
      run_seq(1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         run_seq(1'($urandom_range(0, 1)), 1'b0);
      run_seq(1'b0, 1'b1);
      run_seq(1'b1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
